// File: rtl/event_pulse_stretcher_pkg.sv
// Shared types and helpers for the event pulse stretcher.
// State encoding, queue-control bundle and the us-to-cycles helper.
package event_pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_e;

  // Per-cycle decisions for the pending-event counter.
  typedef struct packed {
    logic inc;
    logic dec;
    logic full;
  } q_ctrl_t;

  localparam logic [31:0] CYC_ONE = 32'd1;

  // Also used by the key debouncer for its hold count.
  function automatic logic [31:0] cycles_from_us(
    input logic [31:0] freq_mhz,
    input logic [31:0] us
  );
    return freq_mhz * us;
  endfunction

endpackage

// File: rtl/event_pulse_stretcher_cycle_timer.sv
// Free-running cycle counter with clear, enable and terminal count.
// Ports: clk, rst_n, i_clr, i_en, i_limit (32b), o_done.
module cycle_timer
  import event_pulse_stretcher_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [31:0] i_limit,
  output logic        o_done
);

  logic [31:0] r_cnt;
  logic [31:0] w_last;

  assign w_last = i_limit - CYC_ONE;
  assign o_done = i_en && (r_cnt == w_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CYC_ONE;
    end
  end

endmodule

// File: rtl/event_pulse_stretcher.sv
// Turns one-cycle event strobes into fixed-width LED pulses + gap.
// Ports: clk, rst_n, pulse_in -> led_out, busy, pending, ovf.
// Option: STRETCH_OVF_FLAG_EN enables the sticky overflow flag.
module event_pulse_stretcher
  import event_pulse_stretcher_pkg::*;
#(
  parameter logic [31:0] SYS_CLK_FREQ = 32'd10,
  parameter logic [31:0] ON_TIME      = 32'd1,
  parameter logic [31:0] OFF_TIME     = 32'd1,
  parameter int          PEND_W       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pulse_in,
  output logic              led_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              ovf
);

  localparam logic [31:0] ON_CYC =
    cycles_from_us(SYS_CLK_FREQ, ON_TIME);
  localparam logic [31:0] OFF_CYC =
    cycles_from_us(SYS_CLK_FREQ, OFF_TIME);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE =
    {{(PEND_W-1){1'b0}}, 1'b1};

  state_e            r_state;
  logic              r_led;
  logic [PEND_W-1:0] r_pend;

  logic              w_done;
  logic              w_en;
  logic              w_clr;
  logic [31:0]       w_limit;
  logic              w_end_off;
  q_ctrl_t           w_q;
  logic [PEND_W-1:0] w_pend_nxt;

  assign w_en    = (r_state != ST_IDLE);
  // Counter sits at zero while idle and restarts on every phase end.
  assign w_clr   = (r_state == ST_IDLE) || w_done;
  assign w_limit = (r_state == ST_ON) ? ON_CYC : OFF_CYC;

  cycle_timer u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_clr),
    .i_en    (w_en),
    .i_limit (w_limit),
    .o_done  (w_done)
  );

  assign w_end_off = (r_state == ST_OFF) && w_done;

  // A strobe on the last gap cycle starts the next pulse directly,
  // so it never enters the queue.
  always_comb begin
    w_q      = '0;
    w_q.inc  = pulse_in && w_en && !w_end_off;
    w_q.dec  = w_end_off && !pulse_in && (r_pend != '0);
    w_q.full = (r_pend == PEND_MAX);
  end

  always_comb begin
    w_pend_nxt = r_pend;
    unique case (1'b1)
      w_q.inc && w_q.dec: w_pend_nxt = r_pend;
      w_q.inc: begin
        if (!w_q.full) begin
          w_pend_nxt = r_pend + PEND_ONE;
        end
      end
      w_q.dec: w_pend_nxt = r_pend - PEND_ONE;
      default: w_pend_nxt = r_pend;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_led   <= 1'b0;
      r_pend  <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      unique case (r_state)
        ST_IDLE: begin
          if (pulse_in) begin
            r_state <= ST_ON;
            r_led   <= 1'b1;
          end
        end
        ST_ON: begin
          if (w_done) begin
            r_state <= ST_OFF;
            r_led   <= 1'b0;
          end
        end
        ST_OFF: begin
          if (w_done) begin
            if (pulse_in || (r_pend != '0)) begin
              r_state <= ST_ON;
              r_led   <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_led   <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_led   <= 1'b0;
        end
      endcase
    end
  end

  assign led_out = r_led;
  assign busy    = (r_state != ST_IDLE);
  assign pending = r_pend;

`ifdef STRETCH_OVF_FLAG_EN
  logic r_ovf;
  logic w_drop;

  assign w_drop = w_q.inc && w_q.full && !w_q.dec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_event_pulse_stretcher.sv
// Bench for event_pulse_stretcher: directed scenarios + random strobes.
// Outputs compared each cycle against a period-based reference model.
module tb_event_pulse_stretcher;

  localparam int SYS  = 10;
  localparam int ONT  = 1;
  localparam int OFFT = 1;
  localparam int PW   = 2;
  localparam int ONC  = SYS * ONT;
  localparam int PER  = ONC + SYS * OFFT;
  localparam int CAP  = (1 << PW) - 1;

  logic          clk;
  logic          rst_n;
  logic          pulse_in;
  logic          led_out;
  logic          busy;
  logic [PW-1:0] pending;
  logic          ovf;

  int checks;
  int failures;

  event_pulse_stretcher #(
    .SYS_CLK_FREQ (32'(SYS)),
    .ON_TIME      (32'(ONT)),
    .OFF_TIME     (32'(OFFT)),
    .PEND_W       (PW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pulse_in (pulse_in),
    .led_out  (led_out),
    .busy     (busy),
    .pending  (pending),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Reference model: a pulse occupies a PER-cycle slot, led high in
  // the first ONC cycles of the slot.
  bit m_act;
  int m_t;
  int m_pend;
  bit m_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act  = 0;
      m_t    = 0;
      m_pend = 0;
      m_ovf  = 0;
    end else if (!m_act) begin
      if (pulse_in) begin
        m_act = 1;
        m_t   = 0;
      end
    end else if (m_t == PER - 1) begin
      if (pulse_in) begin
        m_t = 0;
      end else if (m_pend > 0) begin
        m_pend--;
        m_t = 0;
      end else begin
        m_act = 0;
        m_t   = 0;
      end
    end else begin
      m_t++;
      if (pulse_in) begin
        if (m_pend == CAP) m_ovf = 1;
        else m_pend++;
      end
    end
  end

  bit run_cmp;

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("led", 32'(led_out), 32'(m_act && m_t < ONC));
      chk("busy", 32'(busy), 32'(m_act));
      chk("pending", 32'(pending), 32'(m_pend));
`ifdef STRETCH_OVF_FLAG_EN
      chk("ovf", 32'(ovf), 32'(m_ovf));
`else
      chk("ovf", 32'(ovf), 32'd0);
`endif
    end
  end

  int  n_busy, n_led, n_rise, n_pmax;
  bit  prev_led;

  task automatic zero_cnt();
    n_busy   = 0;
    n_led    = 0;
    n_rise   = 0;
    n_pmax   = 0;
    prev_led = led_out;
  endtask

  task automatic tick(input bit p);
    pulse_in = p;
    @(posedge clk);
    @(negedge clk);
    if (busy) n_busy++;
    if (led_out) n_led++;
    if (led_out && !prev_led) n_rise++;
    if (int'(pending) > n_pmax) n_pmax = int'(pending);
    prev_led = led_out;
  endtask

  task automatic drain(input string nm);
    int g;
    g = 0;
    while (busy && g < 500) begin
      tick(0);
      g++;
    end
    if (g >= 500) chk({nm, "_timeout"}, 32'(busy), 32'd0);
  endtask

  logic exp_ovf;

  initial begin
    checks   = 0;
    failures = 0;
    run_cmp  = 0;
    pulse_in = 0;
    rst_n    = 0;
`ifdef STRETCH_OVF_FLAG_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_led", 32'(led_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pend", 32'(pending), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst_n   = 1;
    run_cmp = 1;
    repeat (4) tick(0);

    // Single strobe: 10 cycles lit, 20 busy.
    zero_cnt();
    tick(1);
    chk("t1_led0", 32'(led_out), 32'd1);
    chk("t1_pend", 32'(pending), 32'd0);
    drain("t1");
    chk("t1_nled", 32'(n_led), 32'd10);
    chk("t1_nbusy", 32'(n_busy), 32'd20);
    chk("t1_pmax", 32'(n_pmax), 32'd0);
    repeat (3) tick(0);

    // Two strobes 3 cycles apart.
    zero_cnt();
    tick(1);
    tick(0);
    tick(0);
    tick(1);
    chk("t2_pend", 32'(pending), 32'd1);
    drain("t2");
    chk("t2_nled", 32'(n_led), 32'd20);
    chk("t2_nbusy", 32'(n_busy), 32'd40);
    chk("t2_rise", 32'(n_rise), 32'd2);
    repeat (3) tick(0);

    // Held for 6 cycles: 1 direct + 3 queued + 2 dropped.
    zero_cnt();
    repeat (4) tick(1);
    chk("t3_pend4", 32'(pending), 32'd3);
    chk("t3_ovf4", 32'(ovf), 32'd0);
    tick(1);
    chk("t3_ovf5", 32'(ovf), 32'(exp_ovf));
    tick(1);
    drain("t3");
    chk("t3_rise", 32'(n_rise), 32'd4);
    chk("t3_nbusy", 32'(n_busy), 32'd80);
    chk("t3_pmax", 32'(n_pmax), 32'd3);
    repeat (3) tick(0);

    // Strobe on final gap cycle with two queued.
    zero_cnt();
    repeat (3) tick(1);
    repeat (17) tick(0);
    chk("t4_pend", 32'(pending), 32'd2);
    chk("t4_gap", 32'(led_out), 32'd0);
    tick(1);
    chk("t4_led", 32'(led_out), 32'd1);
    chk("t4_pend2", 32'(pending), 32'd2);
    drain("t4");
    chk("t4_rise", 32'(n_rise), 32'd4);
    repeat (3) tick(0);

    // Asynchronous reset mid-pulse.
    tick(1);
    tick(1);
    repeat (3) tick(0);
    chk("t5_pre", 32'(pending), 32'd1);
    #2 rst_n = 0;
    #1;
    chk("t5_led", 32'(led_out), 32'd0);
    chk("t5_pend", 32'(pending), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    zero_cnt();
    repeat (30) tick(0);
    chk("t5_rise", 32'(n_rise), 32'd0);
    chk("t5_nbusy", 32'(n_busy), 32'd0);

    // Random strobes, mixed sparse and bursty.
    for (int i = 0; i < 3000; i++) begin
      if (i % 600 < 300) tick($urandom_range(0, 19) == 0);
      else tick($urandom_range(0, 9) < 4);
    end
    drain("rnd");

    run_cmp = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
